uart_wb_bridge: RTL and testbench
=================================

# uart_wb_bridge

Parametrised byte-stream-to-Wishbone command bridge placed between the UART byte interface and the DDR3 controller's Wishbone slave port. It replaces single-character ASCII poking with framed multi-byte commands: a full-width address and full-width write data go in, and full-width read data comes back. It tracks the pipelined-Wishbone stall/ack handshake, aborts hung transactions on timeout and serialises responses under transmit backpressure.

## Interface
Parameters:
- WB_ADDR_BITS, 24: Wishbone address width; NA = ceil(WB_ADDR_BITS/8) address bytes per frame.
- WB_DATA_BITS, 32: Wishbone data width, multiple of 8; ND = WB_DATA_BITS/8 data bytes.
- TIMEOUT_CYCLES, 1023: maximum cycles from REQ entry to ack before abort; ≥ 2.

Ports:
- i_controller_clk  in  1  sole clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rx_tdata  in  8  received byte.
- i_rx_tvalid  in  1  received byte valid.
- o_rx_tready  out  1  bridge can accept a byte.
- o_tx_tdata  out  8  response byte.
- o_tx_tvalid  out  1  response byte valid.
- i_tx_tready  in  1  transmitter accepts byte.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls.
- o_wb_addr  out  WB_ADDR_BITS  request address.
- o_wb_data  out  WB_DATA_BITS  write data.
- o_wb_sel  out  WB_DATA_BITS/8  byte strobes; all ones on every request.
- i_wb_stall, i_wb_ack  in  1 each  slave stall / ack.
- i_wb_data  in  WB_DATA_BITS  read data, valid with i_wb_ack.
- o_busy  out  1  state ≠ IDLE.
- o_err  out  1  sticky timeout flag; cleared only by reset.

## Operation
- All outputs registered. Reset values: every output 0 (including o_rx_tready); state IDLE. o_rx_tready rises the first cycle after reset release.
- Byte accepted when i_rx_tvalid && o_rx_tready. o_rx_tready = 1 only in IDLE, ADDR, DATA.
- IDLE: 0x57 'W' → ADDR, we=1. 0x52 'R' → ADDR, we=0. Any other byte is consumed → RESP with the single byte 0x3F '?'.
- ADDR: shift in NA bytes MSB-first (addr = {addr, byte}, truncated to WB_ADDR_BITS). After the last byte: → DATA if we, else → REQ.
- DATA: shift in ND bytes MSB-first into the write register. After the last byte → REQ.
- REQ: o_wb_cyc=o_wb_stb=1 with addr, data and we held stable. On the first cycle with !i_wb_stall the request is accepted; stb drops the next cycle and the state → WAIT_ACK. Exactly one accepted strobe per frame.
- WAIT_ACK: cyc held. On i_wb_ack:
  - read: capture i_wb_data → RESP with ND bytes MSB-first.
  - write: → RESP with 0x4B 'K'.
  - Cyc drops on the cycle after the ack.
- An ack in the same cycle as acceptance is treated as a WAIT_ACK ack.
- Timeout: a counter clears on REQ entry and increments every cycle in REQ/WAIT_ACK. When it reaches TIMEOUT_CYCLES without an ack:
  - cyc and stb drop next cycle (bus abort);
  - o_err is set;
  - → RESP with 0x54 'T'.
  - Acks arriving later are ignored.
- RESP: o_tx_tvalid=1, o_tx_tdata held stable until i_tx_tready. After each handshake the next byte is presented on the following cycle, so tvalid stays high between bytes. The last handshake → IDLE, with tvalid 0 the next cycle.
- Reset mid-frame or mid-transaction discards all partial state immediately (async). cyc/stb/tvalid drop with reset.

## Timing
- Last frame byte accepted at cycle N → o_wb_stb=1 at N+1.
- Stall low at cycle S with stb=1 → stb=0 at S+1.
- Ack at cycle A → o_tx_tvalid=1 with the first response byte at A+1, and o_wb_cyc=0 at A+1.
- Sustained i_tx_tready=1: ND response bytes in ND consecutive cycles.
- Timeout asserted TIMEOUT_CYCLES cycles after REQ entry: 'T' valid the next cycle.
- Minimum write turnaround (no stall, ack 1 cycle after accept): last byte N, stb N+1, ack N+2, 'K' valid N+3.

## Test plan
Bench parameters: WB_ADDR_BITS=24, WB_DATA_BITS=32, TIMEOUT_CYCLES=16.
- Write: rx 57 00 12 34 DE AD BE EF; slave acks 1 cycle after accept → one strobe with addr=0x001234, data=0xDEADBEEF, we=1, sel=0xF; tx exactly 4B; o_busy returns to 0.
- Read with stall: rx 52 AB CD EF; i_wb_stall=1 for 5 cycles, then ack with 0xCAFEF00D → stb held 6 cycles with stable addr=0xABCDEF, we=0; single acceptance; tx CA FE F0 0D in order.
- Timeout: read frame, slave never acks → cyc drops after 16 cycles; tx 54; o_err=1 and stays 1 across a following successful write (tx 4B).
- Bad opcode and backpressure: rx 41 with i_tx_tready=0 for 10 cycles → o_tx_tvalid=1 and o_tx_tdata=3F stable for all 10 cycles; one byte is sent on release; the next frame parses normally.
- Reset mid-frame: rx 57 00 12, then pulse i_rst_n low for 2 cycles → all outputs 0 during reset; o_err=0 afterwards; frame 52 00 00 01 then issues a read at addr 0x000001.
- Late ack: after a timeout abort, inject i_wb_ack with 0x11111111 → no extra tx byte; state remains IDLE.

Source files
------------

// File: rtl/uart_wb_bridge.sv
// Framed byte-stream to pipelined-Wishbone command bridge: 'W'/'R' + address (+ data) in,
// 'K' / read data / '?' / 'T' out. Every output comes straight from a register.
module uart_wb_bridge #(
  parameter int WB_ADDR_BITS   = 24,
  parameter int WB_DATA_BITS   = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                      i_controller_clk,
  input  logic                      i_rst_n,
  input  logic [7:0]                i_rx_tdata,
  input  logic                      i_rx_tvalid,
  output logic                      o_rx_tready,
  output logic [7:0]                o_tx_tdata,
  output logic                      o_tx_tvalid,
  input  logic                      i_tx_tready,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_we,
  output logic [WB_ADDR_BITS-1:0]   o_wb_addr,
  output logic [WB_DATA_BITS-1:0]   o_wb_data,
  output logic [WB_DATA_BITS/8-1:0] o_wb_sel,
  input  logic                      i_wb_stall,
  input  logic                      i_wb_ack,
  input  logic [WB_DATA_BITS-1:0]   i_wb_data,
  output logic                      o_busy,
  output logic                      o_err
);
  localparam int NA = (WB_ADDR_BITS + 7) / 8;
  localparam int ND = WB_DATA_BITS / 8;
  localparam int CW = $clog2((NA > ND ? NA : ND) + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT, S_RESP} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_we, w_we_nxt;
  logic [WB_ADDR_BITS-1:0] r_addr, w_addr_nxt;
  logic [WB_DATA_BITS-1:0] r_data, w_data_nxt;
  logic [WB_DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [TW-1:0]           r_tmo, w_tmo_nxt;
  logic [7:0]              r_tx_tdata, w_txd_nxt;
  logic                    r_err, w_err_nxt;
  logic                    r_rx_tready, r_tx_tvalid, r_cyc, r_stb, r_busy;
  logic [ND-1:0]           r_sel;
  logic                    w_rx_fire, w_tx_fire, w_acked, w_cyc_nxt;

  assign w_rx_fire = i_rx_tvalid && r_rx_tready;
  assign w_tx_fire = r_tx_tvalid && i_tx_tready;
  // An ack coinciding with acceptance counts; an ack before acceptance is not ours.
  assign w_acked   = i_wb_ack && (r_state == S_WAIT || (r_state == S_REQ && !i_wb_stall));
  assign w_cyc_nxt = (w_state_nxt == S_REQ) || (w_state_nxt == S_WAIT);

  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_txd_nxt   = r_tx_tdata;
    w_err_nxt   = r_err;
    w_tmo_nxt   = '0;
    case (r_state)
      S_IDLE: if (w_rx_fire) begin
        if (i_rx_tdata == 8'h57 || i_rx_tdata == 8'h52) begin
          w_we_nxt    = (i_rx_tdata == 8'h57);
          w_cnt_nxt   = CW'(NA);
          w_state_nxt = S_ADDR;
        end else begin
          w_txd_nxt   = 8'h3F;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_RESP;
        end
      end
      S_ADDR: if (w_rx_fire) begin
        w_addr_nxt = WB_ADDR_BITS'({r_addr, i_rx_tdata});
        w_cnt_nxt  = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          if (r_we) begin
            w_cnt_nxt   = CW'(ND);
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_DATA: if (w_rx_fire) begin
        w_data_nxt = WB_DATA_BITS'({r_data, i_rx_tdata});
        w_cnt_nxt  = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_nxt = S_REQ;
      end
      S_REQ, S_WAIT: begin
        w_tmo_nxt = r_tmo + TW'(1);
        if (w_acked) begin
          w_state_nxt = S_RESP;
          if (r_we) begin
            w_txd_nxt = 8'h4B;
            w_cnt_nxt = CW'(1);
          end else begin
            w_txd_nxt   = i_wb_data[WB_DATA_BITS-1 -: 8];
            w_shift_nxt = i_wb_data << 8;
            w_cnt_nxt   = CW'(ND);
          end
        end else if (r_tmo == TW'(TIMEOUT_CYCLES)) begin
          w_txd_nxt   = 8'h54;
          w_cnt_nxt   = CW'(1);
          w_err_nxt   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_state == S_REQ && !i_wb_stall) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP: if (w_tx_fire) begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_txd_nxt   = r_shift[WB_DATA_BITS-1 -: 8];
          w_shift_nxt = r_shift << 8;
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of what the next state implies.
  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_tx_tdata  <= '0;
      r_err       <= 1'b0;
      r_rx_tready <= 1'b0;
      r_tx_tvalid <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_sel       <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tmo       <= w_tmo_nxt;
      r_tx_tdata  <= w_txd_nxt;
      r_err       <= w_err_nxt;
      r_rx_tready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ADDR) || (w_state_nxt == S_DATA);
      r_tx_tvalid <= (w_state_nxt == S_RESP);
      r_cyc       <= w_cyc_nxt;
      r_stb       <= (w_state_nxt == S_REQ);
      r_sel       <= {ND{w_cyc_nxt}};
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign o_rx_tready = r_rx_tready;
  assign o_tx_tdata  = r_tx_tdata;
  assign o_tx_tvalid = r_tx_tvalid;
  assign o_wb_cyc    = r_cyc;
  assign o_wb_stb    = r_stb;
  assign o_wb_we     = r_we;
  assign o_wb_addr   = r_addr;
  assign o_wb_data   = r_data;
  assign o_wb_sel    = r_sel;
  assign o_busy      = r_busy;
  assign o_err       = r_err;
endmodule

// File: tb/tb_uart_wb_bridge.sv
// Bench for uart_wb_bridge: scripted frames plus randomized frames against a frame-level model,
// with a Wishbone slave model (programmable stall / ack delay) and a bus/stream monitor.
module tb_uart_wb_bridge;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_rx_tdata = '0;
  logic        i_rx_tvalid = 1'b0;
  logic        o_rx_tready;
  logic [7:0]  o_tx_tdata;
  logic        o_tx_tvalid;
  logic        i_tx_tready = 1'b0;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [23:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall = 1'b0;
  logic        i_wb_ack = 1'b0;
  logic [31:0] i_wb_data = '0;
  logic        o_busy, o_err;

  uart_wb_bridge #(.WB_ADDR_BITS(24), .WB_DATA_BITS(32), .TIMEOUT_CYCLES(TMO)) dut (
    .i_controller_clk(clk), .i_rst_n(i_rst_n),
    .i_rx_tdata(i_rx_tdata), .i_rx_tvalid(i_rx_tvalid), .o_rx_tready(o_rx_tready),
    .o_tx_tdata(o_tx_tdata), .o_tx_tvalid(o_tx_tvalid), .i_tx_tready(i_tx_tready),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;

  // Slave model knobs (written by tests only)
  int          sl_stall_n = 0;
  int          sl_ack_dly = 1;
  logic [31:0] sl_rdata = '0;
  int          inj_req = 0;
  logic        bp_mode = 1'b0;
  logic        tx_rdy_set = 1'b1;

  // Slave model: stall the first sl_stall_n strobe cycles, ack sl_ack_dly cycles after accept
  // (0 = same cycle, negative = never); inj_req requests a stray ack.
  int   inj_done = 0;
  int   stall_cnt = 0;
  int   wt = 0;
  logic pending = 1'b0;
  always @(negedge clk) begin
    i_wb_ack = 1'b0;
    if (inj_req != inj_done) begin
      i_wb_ack  = 1'b1;
      i_wb_data = sl_rdata;
      inj_done++;
    end else if (!o_wb_cyc) begin
      pending    = 1'b0;
      stall_cnt  = 0;
      i_wb_stall = 1'b0;
    end else if (o_wb_stb && !pending) begin
      if (stall_cnt < sl_stall_n) begin
        i_wb_stall = 1'b1;
        stall_cnt++;
      end else begin
        i_wb_stall = 1'b0;
        pending    = 1'b1;
        wt         = sl_ack_dly;
        if (wt == 0) begin i_wb_ack = 1'b1; i_wb_data = sl_rdata; end
      end
    end else if (pending && wt > 0) begin
      wt--;
      if (wt == 0) begin i_wb_ack = 1'b1; i_wb_data = sl_rdata; end
    end
  end

  always @(negedge clk) i_tx_tready = bp_mode ? 1'($urandom_range(0, 1)) : tx_rdy_set;

  // Monitor: samples 1ns before each rising edge
  typedef struct {logic [23:0] a; logic [31:0] d; logic we; logic [3:0] sel;} acc_t;
  acc_t       acc_q[$];
  logic [7:0] tx_q[$];
  int         tx_cyc_q[$];
  int cyc_no = 0, stb_cycles = 0, addr_unstable = 0, tdata_unstable = 0;
  int last_rx_cyc = 0, tv_rise_cyc = 0, cyc_rise_cyc = 0, cyc_fall_cyc = 0;
  logic p_stb = 0, p_cyc = 0, p_tv = 0, p_tv_wait = 0, p_we = 0;
  logic [23:0] p_addr = '0;
  logic [31:0] p_data = '0;
  logic [7:0]  p_tdata = '0;
  always @(negedge clk) begin
    #4;
    cyc_no++;
    if (o_rx_tready && i_rx_tvalid) last_rx_cyc = cyc_no;
    if (o_wb_stb) stb_cycles++;
    if (o_wb_stb && p_stb && (o_wb_addr != p_addr || o_wb_we != p_we || o_wb_data != p_data))
      addr_unstable++;
    if (o_wb_cyc && o_wb_stb && !i_wb_stall) acc_q.push_back('{o_wb_addr, o_wb_data, o_wb_we, o_wb_sel});
    if (o_wb_cyc && !p_cyc) cyc_rise_cyc = cyc_no;
    if (!o_wb_cyc && p_cyc) cyc_fall_cyc = cyc_no;
    if (o_tx_tvalid && !p_tv) tv_rise_cyc = cyc_no;
    if (o_tx_tvalid && p_tv_wait && o_tx_tdata != p_tdata) tdata_unstable++;
    if (o_tx_tvalid && i_tx_tready) begin tx_q.push_back(o_tx_tdata); tx_cyc_q.push_back(cyc_no); end
    p_tv_wait = o_tx_tvalid && !i_tx_tready;
    p_stb = o_wb_stb; p_cyc = o_wb_cyc; p_tv = o_tx_tvalid; p_we = o_wb_we;
    p_addr = o_wb_addr; p_data = o_wb_data; p_tdata = o_tx_tdata;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    i_rx_tvalid = 1'b1;
    i_rx_tdata  = b;
    while (!o_rx_tready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!o_rx_tready) begin
      fails++;
      $display("FAIL rx_accept: byte %h tready=%b, required 1 within 200 cycles", b, o_rx_tready);
    end else @(posedge clk);
    #1 i_rx_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send_byte(f[i]);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (o_busy && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (o_busy) begin fails++; $display("FAIL %s: busy=%b after 500 cycles, required 0", nm, o_busy); end
  endtask

  // Frame-level reference: what the bridge should send back and whether it should hit the bus
  function automatic void model(input logic [7:0] op, input logic [31:0] rd,
                                output logic [7:0] exp[$], output bit strobe);
    exp = {};
    strobe = (op == 8'h57 || op == 8'h52);
    if (op == 8'h57) exp.push_back(8'h4B);
    else if (op == 8'h52) for (int i = 3; i >= 0; i--) exp.push_back(rd[8*i +: 8]);
    else exp.push_back(8'h3F);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({o_rx_tready, o_tx_tdata, o_tx_tvalid, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr,
         o_wb_data, o_wb_sel, o_busy, o_err} !== '0) begin
      fails++; $display("FAIL reset_outputs: some output nonzero (tready=%b cyc=%b), required all 0", o_rx_tready, o_wb_cyc);
    end
    i_rst_n = 1'b1;
    #1 checks++;
    if (o_rx_tready !== 1'b0) begin fails++; $display("FAIL reset_release_tready: got %b, required 0", o_rx_tready); end
    @(negedge clk);
    checks++;
    if (o_rx_tready !== 1'b1 || o_busy !== 1'b0) begin
      fails++; $display("FAIL post_reset: tready=%b busy=%b, required 1 0", o_rx_tready, o_busy);
    end
  endtask

  task automatic test_write(input string nm, input logic exp_err);
    int a0, t0;
    logic [7:0] f[$];
    a0 = acc_q.size(); t0 = tx_q.size();
    sl_stall_n = 0; sl_ack_dly = 1;
    f = {8'h57, 8'h00, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(f);
    wait_idle(nm);
    checks++;
    if (acc_q.size() - a0 != 1) begin fails++; $display("FAIL %s_strobes: got %0d, required 1", nm, acc_q.size() - a0); end
    else begin
      checks++;
      if (acc_q[a0].a !== 24'h001234 || acc_q[a0].d !== 32'hDEADBEEF || acc_q[a0].we !== 1'b1 || acc_q[a0].sel !== 4'hF) begin
        fails++; $display("FAIL %s_bus: got addr=%h data=%h we=%b sel=%h, required 001234 deadbeef 1 f",
                          nm, acc_q[a0].a, acc_q[a0].d, acc_q[a0].we, acc_q[a0].sel);
      end
    end
    checks++;
    if (tx_q.size() - t0 != 1 || tx_q[tx_q.size()-1] !== 8'h4B) begin
      fails++; $display("FAIL %s_tx: got %0d bytes last=%h, required 1 byte 4b", nm, tx_q.size() - t0, tx_q[tx_q.size()-1]);
    end
    checks++;
    if (tv_rise_cyc - last_rx_cyc != 3) begin
      fails++; $display("FAIL %s_latency: K valid %0d cycles after last byte, required 3", nm, tv_rise_cyc - last_rx_cyc);
    end
    checks++;
    if (o_busy !== 1'b0 || o_err !== exp_err) begin
      fails++; $display("FAIL %s_flags: busy=%b err=%b, required 0 %b", nm, o_busy, o_err, exp_err);
    end
  endtask

  task automatic test_read_stall();
    int a0, t0, s0, u0;
    logic [7:0] f[$];
    logic [7:0] exp[$];
    bit strobe;
    a0 = acc_q.size(); t0 = tx_q.size(); s0 = stb_cycles; u0 = addr_unstable;
    sl_stall_n = 5; sl_ack_dly = 1; sl_rdata = 32'hCAFEF00D;
    model(8'h52, sl_rdata, exp, strobe);
    f = {8'h52, 8'hAB, 8'hCD, 8'hEF};
    send_frame(f);
    wait_idle("read_idle");
    checks++;
    if (stb_cycles - s0 != 6 || addr_unstable != u0) begin
      fails++; $display("FAIL read_stb_hold: stb cycles=%0d unstable=%0d, required 6 0", stb_cycles - s0, addr_unstable - u0);
    end
    checks++;
    if (acc_q.size() - a0 != 1 || acc_q[acc_q.size()-1].a !== 24'hABCDEF || acc_q[acc_q.size()-1].we !== 1'b0) begin
      fails++; $display("FAIL read_accept: got %0d accepts addr=%h we=%b, required 1 abcdef 0",
                        acc_q.size() - a0, acc_q[acc_q.size()-1].a, acc_q[acc_q.size()-1].we);
    end
    checks++;
    if (tx_q.size() - t0 != 4) begin fails++; $display("FAIL read_tx_count: got %0d, required 4", tx_q.size() - t0); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (tx_q[t0+i] !== exp[i]) begin fails++; $display("FAIL read_tx_byte%0d: got %h, required %h", i, tx_q[t0+i], exp[i]); end
      end
      checks++;
      if (tx_cyc_q[t0+3] - tx_cyc_q[t0] != 3) begin
        fails++; $display("FAIL read_tx_burst: 4 bytes span %0d cycles, required 3", tx_cyc_q[t0+3] - tx_cyc_q[t0]);
      end
    end
  endtask

  task automatic test_timeout();
    int t0;
    logic [7:0] f[$];
    t0 = tx_q.size();
    sl_stall_n = 0; sl_ack_dly = -1;
    f = {8'h52, 8'h00, 8'h00, 8'h10};
    send_frame(f);
    wait_idle("timeout_idle");
    checks++;
    if (cyc_fall_cyc - cyc_rise_cyc != TMO + 1 || tv_rise_cyc != cyc_fall_cyc) begin
      fails++; $display("FAIL timeout_timing: cyc high %0d cycles, T at +%0d, required %0d and %0d",
                        cyc_fall_cyc - cyc_rise_cyc, tv_rise_cyc - cyc_rise_cyc, TMO + 1, TMO + 1);
    end
    checks++;
    if (tx_q.size() - t0 != 1 || tx_q[tx_q.size()-1] !== 8'h54) begin
      fails++; $display("FAIL timeout_tx: got %0d bytes last=%h, required 1 byte 54", tx_q.size() - t0, tx_q[tx_q.size()-1]);
    end
    checks++;
    if (o_err !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b, required 1", o_err); end
  endtask

  task automatic test_late_ack();
    int t0;
    t0 = tx_q.size();
    sl_rdata = 32'h11111111;
    inj_req++;
    repeat (6) @(negedge clk);
    checks++;
    if (tx_q.size() != t0 || o_tx_tvalid !== 1'b0 || o_busy !== 1'b0 || o_rx_tready !== 1'b1) begin
      fails++; $display("FAIL late_ack: extra bytes=%0d tvalid=%b busy=%b tready=%b, required 0 0 0 1",
                        tx_q.size() - t0, o_tx_tvalid, o_busy, o_rx_tready);
    end
    test_write("write_after_timeout", 1'b1);
  endtask

  task automatic test_bad_opcode_bp();
    int t0, bad;
    t0 = tx_q.size(); bad = 0;
    @(posedge clk); #1 tx_rdy_set = 1'b0;
    send_byte(8'h41);
    repeat (10) begin
      @(negedge clk);
      if (o_tx_tvalid !== 1'b1 || o_tx_tdata !== 8'h3F) bad++;
    end
    checks++;
    if (bad != 0) begin fails++; $display("FAIL badop_hold: %0d cycles not valid 3f, required 0", bad); end
    #1 tx_rdy_set = 1'b1;
    wait_idle("badop_idle");
    checks++;
    if (tx_q.size() - t0 != 1 || tx_q[tx_q.size()-1] !== 8'h3F) begin
      fails++; $display("FAIL badop_tx: got %0d bytes last=%h, required 1 byte 3f", tx_q.size() - t0, tx_q[tx_q.size()-1]);
    end
    test_write("write_after_badop", 1'b1);
  endtask

  task automatic test_reset_midframe();
    int a0, t0;
    logic [7:0] f[$];
    logic [7:0] exp[$];
    bit strobe;
    f = {8'h57, 8'h00, 8'h12};
    send_frame(f);
    @(negedge clk);
    i_rst_n = 1'b0;
    repeat (2) begin
      #1 checks++;
      if ({o_rx_tready, o_tx_tdata, o_tx_tvalid, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr,
           o_wb_data, o_wb_sel, o_busy, o_err} !== '0) begin
        fails++; $display("FAIL midreset_outputs: busy=%b err=%b tready=%b, required all 0", o_busy, o_err, o_rx_tready);
      end
      @(negedge clk);
    end
    i_rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_err !== 1'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL midreset_state: err=%b busy=%b, required 0 0", o_err, o_busy); end
    a0 = acc_q.size(); t0 = tx_q.size();
    sl_stall_n = 0; sl_ack_dly = 1; sl_rdata = $urandom;
    model(8'h52, sl_rdata, exp, strobe);
    f = {8'h52, 8'h00, 8'h00, 8'h01};
    send_frame(f);
    wait_idle("midreset_idle");
    checks++;
    if (acc_q.size() - a0 != 1 || acc_q[acc_q.size()-1].a !== 24'h000001 || acc_q[acc_q.size()-1].we !== 1'b0) begin
      fails++; $display("FAIL midreset_read: %0d accepts addr=%h we=%b, required 1 000001 0",
                        acc_q.size() - a0, acc_q[acc_q.size()-1].a, acc_q[acc_q.size()-1].we);
    end
    checks++;
    if (tx_q.size() - t0 != 4 || tx_q[t0] !== exp[0] || tx_q[t0+3] !== exp[3]) begin
      fails++; $display("FAIL midreset_tx: %0d bytes first=%h last=%h, required 4 %h %h",
                        tx_q.size() - t0, tx_q[t0], tx_q[t0+3], exp[0], exp[3]);
    end
  endtask

  task automatic test_random(input int n);
    int a0, t0, u0, bad;
    logic [7:0] op, f[$], exp[$];
    logic [23:0] a;
    logic [31:0] d;
    bit strobe;
    u0 = tdata_unstable;
    bp_mode = 1'b1;
    for (int it = 0; it < n; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 8'h57;
        4, 5, 6, 7: op = 8'h52;
        default: begin
          op = 8'($urandom);
          while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
        end
      endcase
      a = 24'($urandom); d = $urandom;
      sl_stall_n = $urandom_range(0, 3); sl_ack_dly = $urandom_range(0, 3); sl_rdata = $urandom;
      model(op, sl_rdata, exp, strobe);
      f = {op};
      if (strobe) f = {f, a[23:16], a[15:8], a[7:0]};
      if (op == 8'h57) f = {f, d[31:24], d[23:16], d[15:8], d[7:0]};
      a0 = acc_q.size(); t0 = tx_q.size();
      send_frame(f);
      wait_idle("rand_idle");
      checks++;
      if (acc_q.size() - a0 != int'(strobe)) begin
        fails++; $display("FAIL rand%0d_strobes: op=%h got %0d, required %0d", it, op, acc_q.size() - a0, strobe);
      end else if (strobe) begin
        checks++;
        if (acc_q[a0].a !== a || acc_q[a0].we !== (op == 8'h57) || (op == 8'h57 && acc_q[a0].d !== d)) begin
          fails++; $display("FAIL rand%0d_bus: addr=%h we=%b data=%h, required %h %b %h",
                            it, acc_q[a0].a, acc_q[a0].we, acc_q[a0].d, a, op == 8'h57, d);
        end
      end
      checks++;
      if (tx_q.size() - t0 != exp.size()) begin
        fails++; $display("FAIL rand%0d_tx_count: op=%h got %0d, required %0d", it, op, tx_q.size() - t0, exp.size());
      end else begin
        bad = 0;
        foreach (exp[i]) if (tx_q[t0+i] !== exp[i]) bad++;
        checks++;
        if (bad != 0) begin fails++; $display("FAIL rand%0d_tx_bytes: %0d bytes differ, first got %h required %h", it, bad, tx_q[t0], exp[0]); end
      end
    end
    bp_mode = 1'b0;
    checks++;
    if (tdata_unstable != u0) begin fails++; $display("FAIL rand_tdata_stable: %0d changes under backpressure, required 0", tdata_unstable - u0); end
  endtask

  initial begin
    test_reset();
    test_write("write", 1'b0);
    test_read_stall();
    test_timeout();
    test_late_ack();
    test_bad_opcode_bp();
    test_reset_midframe();
    test_random(25);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t reached, required finish before 2000000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
